// File: rtl/colour_sensor_ctrl.sv
// Colour sensor front-end controller.
// Sweeps the RED, BLUE and GREEN filters. Each filter switch is followed by a
// settle window, and then rising edges of the sensor output are counted over
// a gate window. At the end of a sweep the three counts are published, and
// the dominant colour is classified and debounced.
//
//   state  | meaning
//   IDLE   | waiting for en; filter pins parked at RED
//   SETTLE | filter just switched; sensor edges ignored
//   COUNT  | counting sensor rising edges for the current filter
module colour_sensor_ctrl #(
  parameter int GATE_CYCLES   = 100000,
  parameter int SETTLE_CYCLES = 1000,
  parameter int CNT_W         = 12,
  parameter int MIN_TOTAL     = 16,
  parameter int CONFIRM       = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       freq_scale,
  input  logic             signal,
  output logic             S0,
  output logic             S1,
  output logic             S2,
  output logic             S3,
  output logic [CNT_W-1:0] red_cnt,
  output logic [CNT_W-1:0] blue_cnt,
  output logic [CNT_W-1:0] green_cnt,
  output logic             sample_valid,
  output logic [2:0]       color,
  output logic             color_valid
);

  localparam int TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int SUM_W   = CNT_W + 2;
  localparam int STK_W   = $clog2(CONFIRM + 1);

  localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] GATE_LOAD   = TMR_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [SUM_W-1:0] MIN_SUM     = SUM_W'(MIN_TOTAL);
  localparam logic [STK_W-1:0] STK_FULL    = STK_W'(CONFIRM);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_COUNT} state_t;
  // Values double as the {S3,S2} filter-select encoding.
  typedef enum logic [1:0] {CH_RED = 2'b00, CH_BLUE = 2'b10, CH_GREEN = 2'b11} ch_t;

  state_t           state;
  ch_t              ch;
  logic [TMR_W-1:0] timer;
  logic [CNT_W-1:0] edge_cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] hold_r;
  logic [CNT_W-1:0] hold_b;
  logic             sig_meta;
  logic             sig_sync;
  logic             sig_prev;
  logic             sig_rise;
  logic [SUM_W-1:0] sum;
  logic [2:0]       cand;
  logic [2:0]       prev_cand;
  logic [STK_W-1:0] streak;
  logic [STK_W-1:0] streak_next;

  // Two-flop synchroniser for the asynchronous sensor output, plus edge history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_meta <= 1'b0;
      sig_sync <= 1'b0;
      sig_prev <= 1'b0;
    end else begin
      sig_meta <= signal;
      sig_sync <= sig_meta;
      sig_prev <= sig_sync;
    end
  end

  assign sig_rise = sig_sync & ~sig_prev;

  // Saturating edge count including an edge seen in the current clock.
  always_comb begin
    cnt_next = edge_cnt;
    if (sig_rise && (edge_cnt != CNT_MAX)) cnt_next = edge_cnt + 1'b1;
  end

  // Sweep sequencer: filter select, settle/gate timing, per-channel capture and publish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      ch           <= CH_RED;
      timer        <= '0;
      edge_cnt     <= '0;
      hold_r       <= '0;
      hold_b       <= '0;
      red_cnt      <= '0;
      blue_cnt     <= '0;
      green_cnt    <= '0;
      sample_valid <= 1'b0;
      S0           <= 1'b1;
      S1           <= 1'b0;
      S2           <= 1'b0;
      S3           <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (en) begin
            {S1, S0} <= freq_scale;
            ch       <= CH_RED;
            {S3, S2} <= CH_RED;
            timer    <= SETTLE_LOAD;
            state    <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (!en) begin
            state    <= ST_IDLE;
            {S3, S2} <= 2'b00;
          end else if (timer == '0) begin
            edge_cnt <= '0;
            timer    <= GATE_LOAD;
            state    <= ST_COUNT;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        ST_COUNT: begin
          if (!en) begin
            state    <= ST_IDLE;
            {S3, S2} <= 2'b00;
          end else if (timer == '0) begin
            timer <= SETTLE_LOAD;
            state <= ST_SETTLE;
            case (ch)
              CH_RED: begin
                hold_r   <= cnt_next;
                ch       <= CH_BLUE;
                {S3, S2} <= CH_BLUE;
              end
              CH_BLUE: begin
                hold_b   <= cnt_next;
                ch       <= CH_GREEN;
                {S3, S2} <= CH_GREEN;
              end
              default: begin
                // Green is published straight from the counter so the next
                // sweep starts without an extra clock.
                red_cnt      <= hold_r;
                blue_cnt     <= hold_b;
                green_cnt    <= cnt_next;
                sample_valid <= 1'b1;
                ch           <= CH_RED;
                {S3, S2}     <= CH_RED;
                {S1, S0}     <= freq_scale;
              end
            endcase
          end else begin
            edge_cnt <= cnt_next;
            timer    <= timer - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Candidate colour from the published counts: strict maximum above a darkness floor.
  always_comb begin
    sum  = {2'b00, red_cnt} + {2'b00, blue_cnt} + {2'b00, green_cnt};
    cand = 3'b000;
    if (sum >= MIN_SUM) begin
      if (red_cnt > blue_cnt && red_cnt > green_cnt)        cand = 3'b001;
      else if (blue_cnt > red_cnt && blue_cnt > green_cnt)  cand = 3'b010;
      else if (green_cnt > red_cnt && green_cnt > blue_cnt) cand = 3'b100;
    end
    if (cand == prev_cand) streak_next = (streak >= STK_FULL) ? STK_FULL : streak + 1'b1;
    else                   streak_next = STK_W'(1);
  end

  // Debounce: colour updates only after CONFIRM identical consecutive candidates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak      <= '0;
      prev_cand   <= 3'b000;
      color       <= 3'b000;
      color_valid <= 1'b0;
    end else if (sample_valid) begin
      streak    <= streak_next;
      prev_cand <= cand;
      if (streak_next == STK_FULL) begin
        color       <= cand;
        color_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_colour_sensor_ctrl.sv
// Bench for colour_sensor_ctrl: a sensor model whose output period follows the
// selected filter, a scoreboard of expected per-sweep counts and colours, and
// a second narrow-count instance for saturation.
module tb_colour_sensor_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [1:0] freq_scale;
  logic       signal;
  logic       sat_signal;

  logic       S0, S1, S2, S3;
  logic [7:0] red_cnt, blue_cnt, green_cnt;
  logic       sample_valid;
  logic [2:0] color;
  logic       color_valid;

  logic       z_s0, z_s1, z_s2, z_s3;
  logic [3:0] sat_red, sat_blue, sat_green;
  logic       sat_sv;
  logic [2:0] sat_color;
  logic       sat_cv;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int last_sv_cyc = 0;

  int per_r = 4;
  int per_b = 4;
  int per_g = 4;

  typedef struct {
    int r, b, g, tol;
    logic [2:0] col_pre, col;
    logic cv_pre, cv;
  } exp_t;
  exp_t sb[$];

  logic [2:0] m_prev;
  logic [2:0] m_color;
  int         m_streak;
  logic       m_cv;

  colour_sensor_ctrl #(.GATE_CYCLES(100), .SETTLE_CYCLES(10), .CNT_W(8),
                       .MIN_TOTAL(16), .CONFIRM(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .freq_scale(freq_scale), .signal(signal),
    .S0(S0), .S1(S1), .S2(S2), .S3(S3),
    .red_cnt(red_cnt), .blue_cnt(blue_cnt), .green_cnt(green_cnt),
    .sample_valid(sample_valid), .color(color), .color_valid(color_valid));

  colour_sensor_ctrl #(.GATE_CYCLES(100), .SETTLE_CYCLES(10), .CNT_W(4),
                       .MIN_TOTAL(16), .CONFIRM(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .freq_scale(freq_scale), .signal(sat_signal),
    .S0(z_s0), .S1(z_s1), .S2(z_s2), .S3(z_s3),
    .red_cnt(sat_red), .blue_cnt(sat_blue), .green_cnt(sat_green),
    .sample_valid(sat_sv), .color(sat_color), .color_valid(sat_cv));

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Sensor model: square wave whose period depends on the selected filter.
  initial begin
    int phase;
    int p;
    phase      = 0;
    signal     = 1'b0;
    sat_signal = 1'b0;
    forever begin
      @(negedge clk);
      phase++;
      case ({S3, S2})
        2'b10:   p = per_b;
        2'b11:   p = per_g;
        default: p = per_r;
      endcase
      signal     = ((phase % p) < (p / 2));
      sat_signal = ~sat_signal;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  function automatic bit in_tol(int actual, int want, int tol);
    return (actual >= want - tol) && (actual <= want + tol);
  endfunction

  task automatic model_reset();
    m_prev = 3'b000; m_color = 3'b000; m_streak = 0; m_cv = 1'b0;
    sb.delete();
  endtask

  // Push the expected outcome of one sweep with nominal counts r/b/g.
  task automatic push_sweep(int r, int b, int g, int tol);
    exp_t e;
    logic [2:0] cand;
    e.r = r; e.b = b; e.g = g; e.tol = tol;
    e.col_pre = m_color; e.cv_pre = m_cv;
    if (r + b + g < 16)         cand = 3'b000;
    else if (r > b && r > g)    cand = 3'b001;
    else if (b > r && b > g)    cand = 3'b010;
    else if (g > r && g > b)    cand = 3'b100;
    else                        cand = 3'b000;
    if (cand == m_prev) m_streak = (m_streak + 1 > 2) ? 2 : m_streak + 1;
    else                m_streak = 1;
    m_prev = cand;
    if (m_streak == 2) begin m_color = cand; m_cv = 1'b1; end
    e.col = m_color; e.cv = m_cv;
    sb.push_back(e);
  endtask

  task automatic wait_sv(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (sample_valid === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    bit ok;
    int t0;
    exp_t e;
    rst_n = 1'b0; en = 1'b1; freq_scale = 2'b10;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({S3, S2, S1, S0} !== 4'b0001) begin
      fails++; $display("FAIL reset_pins: got S3..S0=%b, required 0001", {S3, S2, S1, S0});
    end
    checks++;
    if ({red_cnt, blue_cnt, green_cnt, sample_valid, color, color_valid} !== '0) begin
      fails++; $display("FAIL reset_outputs: got r=%0d b=%0d g=%0d sv=%b col=%b cv=%b, required all 0",
                        red_cnt, blue_cnt, green_cnt, sample_valid, color, color_valid);
    end
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    checks++;
    if ({S1, S0} !== 2'b10) begin
      fails++; $display("FAIL scale_sampled: got S1S0=%b, required 10", {S1, S0});
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({S3, S2, S1, S0, color, color_valid, sample_valid} !== 9'b0001_000_0_0 ||
        {red_cnt, blue_cnt, green_cnt} !== '0) begin
      fails++; $display("FAIL async_reset: got S3..S0=%b col=%b cv=%b r=%0d b=%0d g=%0d, required 0001 000 0 0 0 0",
                        {S3, S2, S1, S0}, color, color_valid, red_cnt, blue_cnt, green_cnt);
    end
    @(negedge clk);
    freq_scale = 2'b01;
    rst_n = 1'b1;
    t0 = cyc;
    push_sweep(25, 25, 25, 1);
    wait_sv(ok);
    checks++;
    if (!ok) begin fails++; $display("FAIL first_sv_timeout: no sample_valid in 400 clocks, required one"); end
    last_sv_cyc = cyc;
    checks++;
    if (cyc - t0 < 330 || cyc - t0 > 332) begin
      fails++; $display("FAIL first_sv_latency: got %0d clocks, required 330..332", cyc - t0);
    end
    e = sb.pop_front();
    checks++;
    if (!in_tol(red_cnt, e.r, e.tol) || !in_tol(blue_cnt, e.b, e.tol) || !in_tol(green_cnt, e.g, e.tol)) begin
      fails++; $display("FAIL reset_sweep_counts: got r=%0d b=%0d g=%0d, required %0d/%0d/%0d +/-%0d",
                        red_cnt, blue_cnt, green_cnt, e.r, e.b, e.g, e.tol);
    end
    @(negedge clk);
    checks++;
    if ({color_valid, color} !== {e.cv, e.col}) begin
      fails++; $display("FAIL reset_sweep_color: got cv=%b col=%b, required cv=%b col=%b", color_valid, color, e.cv, e.col);
    end
  endtask

  task automatic test_equal();
    bit ok;
    exp_t e;
    push_sweep(25, 25, 25, 1);
    wait_sv(ok);
    checks++;
    if (!ok || cyc - last_sv_cyc != 330) begin
      fails++; $display("FAIL equal_period: got ok=%b interval=%0d, required interval 330", ok, cyc - last_sv_cyc);
    end
    last_sv_cyc = cyc;
    e = sb.pop_front();
    checks++;
    if (!in_tol(red_cnt, e.r, e.tol) || !in_tol(blue_cnt, e.b, e.tol) || !in_tol(green_cnt, e.g, e.tol)) begin
      fails++; $display("FAIL equal_counts: got r=%0d b=%0d g=%0d, required %0d/%0d/%0d +/-%0d",
                        red_cnt, blue_cnt, green_cnt, e.r, e.b, e.g, e.tol);
    end
    checks++;
    if ({color_valid, color} !== {e.cv_pre, e.col_pre}) begin
      fails++; $display("FAIL equal_color_pre: got cv=%b col=%b, required cv=%b col=%b", color_valid, color, e.cv_pre, e.col_pre);
    end
    @(negedge clk);
    checks++;
    if ({color_valid, color} !== {e.cv, e.col}) begin
      fails++; $display("FAIL equal_color_post: got cv=%b col=%b, required cv=%b col=%b", color_valid, color, e.cv, e.col);
    end
  endtask

  // Shared body for multi-sweep colour scenarios with fixed filter periods.
  task automatic test_colour_sweeps(string tag, int pr, int pb, int pg, int nr, int nb, int ng, int tol);
    bit ok;
    exp_t e;
    per_r = pr; per_b = pb; per_g = pg;
    for (int k = 0; k < 2; k++) begin
      push_sweep(nr, nb, ng, tol);
      wait_sv(ok);
      checks++;
      if (!ok) begin fails++; $display("FAIL %s_sv_timeout: sweep %0d gave no sample_valid", tag, k); end
      last_sv_cyc = cyc;
      e = sb.pop_front();
      checks++;
      if (!in_tol(red_cnt, e.r, e.tol) || !in_tol(blue_cnt, e.b, e.tol) || !in_tol(green_cnt, e.g, e.tol)) begin
        fails++; $display("FAIL %s_counts: sweep %0d got r=%0d b=%0d g=%0d, required %0d/%0d/%0d +/-%0d",
                          tag, k, red_cnt, blue_cnt, green_cnt, e.r, e.b, e.g, e.tol);
      end
      checks++;
      if ({color_valid, color} !== {e.cv_pre, e.col_pre}) begin
        fails++; $display("FAIL %s_color_pre: sweep %0d got cv=%b col=%b, required cv=%b col=%b",
                          tag, k, color_valid, color, e.cv_pre, e.col_pre);
      end
      @(negedge clk);
      checks++;
      if ({color_valid, color} !== {e.cv, e.col}) begin
        fails++; $display("FAIL %s_color_post: sweep %0d got cv=%b col=%b, required cv=%b col=%b",
                          tag, k, color_valid, color, e.cv, e.col);
      end
    end
  endtask

  task automatic test_red_dominant();
    test_colour_sweeps("red_dom", 4, 10, 20, 25, 10, 5, 1);
  endtask

  task automatic test_dark();
    test_colour_sweeps("dark", 40, 40, 40, 2, 2, 2, 1);
  endtask

  task automatic test_abort();
    bit ok;
    bit saw_sv;
    int t0;
    exp_t e;
    per_r = 4; per_b = 4; per_g = 4;
    push_sweep(25, 25, 25, 1);
    wait_sv(ok);
    e = sb.pop_front();
    checks++;
    if (!ok || !in_tol(red_cnt, e.r, e.tol) || !in_tol(green_cnt, e.g, e.tol)) begin
      fails++; $display("FAIL abort_pre_sweep: got ok=%b r=%0d g=%0d, required 25/25", ok, red_cnt, green_cnt);
    end
    repeat (170) @(negedge clk);
    checks++;
    if ({S3, S2} !== 2'b10) begin fails++; $display("FAIL blue_select: got S3S2=%b, required 10", {S3, S2}); end
    repeat (110) @(negedge clk);
    checks++;
    if ({S3, S2} !== 2'b11) begin fails++; $display("FAIL green_select: got S3S2=%b, required 11", {S3, S2}); end
    en = 1'b0;
    @(negedge clk);
    checks++;
    if ({S3, S2} !== 2'b00) begin fails++; $display("FAIL abort_pins: got S3S2=%b, required 00", {S3, S2}); end
    saw_sv = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (sample_valid === 1'b1) saw_sv = 1'b1;
    end
    checks++;
    if (saw_sv !== 1'b0) begin fails++; $display("FAIL abort_no_sv: got sample_valid pulse, required none"); end
    checks++;
    if (!in_tol(red_cnt, 25, 1) || !in_tol(blue_cnt, 25, 1) || !in_tol(green_cnt, 25, 1) ||
        {color_valid, color} !== {m_cv, m_color}) begin
      fails++; $display("FAIL abort_hold: got r=%0d b=%0d g=%0d cv=%b col=%b, required 25/25/25 cv=%b col=%b",
                        red_cnt, blue_cnt, green_cnt, color_valid, color, m_cv, m_color);
    end
    freq_scale = 2'b11;
    en = 1'b1;
    t0 = cyc;
    @(negedge clk);
    checks++;
    if ({S3, S2, S1, S0} !== 4'b0011) begin
      fails++; $display("FAIL restart_pins: got S3..S0=%b, required 0011", {S3, S2, S1, S0});
    end
    push_sweep(25, 25, 25, 1);
    wait_sv(ok);
    e = sb.pop_front();
    checks++;
    if (!ok || cyc - t0 < 330 || cyc - t0 > 332) begin
      fails++; $display("FAIL restart_latency: got ok=%b %0d clocks, required 330..332", ok, cyc - t0);
    end
    checks++;
    if (!in_tol(red_cnt, e.r, e.tol) || !in_tol(blue_cnt, e.b, e.tol) || !in_tol(green_cnt, e.g, e.tol)) begin
      fails++; $display("FAIL restart_counts: got r=%0d b=%0d g=%0d, required %0d/%0d/%0d",
                        red_cnt, blue_cnt, green_cnt, e.r, e.b, e.g);
    end
  endtask

  task automatic test_saturation();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (sat_sv === 1'b1) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin fails++; $display("FAIL sat_sv_timeout: no sample_valid on narrow instance"); end
    checks++;
    if (sat_red !== 4'd15 || sat_blue !== 4'd15 || sat_green !== 4'd15) begin
      fails++; $display("FAIL saturation: got r=%0d b=%0d g=%0d, required 15/15/15", sat_red, sat_blue, sat_green);
    end
  endtask

  initial begin
    test_reset();
    test_equal();
    test_red_dominant();
    test_dark();
    test_abort();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
